// File: rtl/seg_probe_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_probe_mux_if
// Purpose  : Signal bundle between the probe sources and push buttons and
//            the seven-segment probe multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_probe_mux_if #(
  parameter int NCH  = 4,
  parameter int DW   = 32,
  parameter int NDIG = 6
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*DW-1:0] probe;
  logic              key_next;
  logic              key_freeze;
  logic [NDIG*7-1:0] hex;
  logic [CW-1:0]     ch_sel;
  logic              frozen;

  // Board side: drives probes and buttons, watches the display
  modport master (
    output probe, key_next, key_freeze,
    input  hex, ch_sel, frozen
  );

  // Multiplexer side
  modport slave (
    input  probe, key_next, key_freeze,
    output hex, ch_sel, frozen
  );
endinterface
`default_nettype wire

// File: rtl/seg_probe_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_probe_mux
// Purpose  : Shows one of NCH probe words as hex on NDIG seven-segment digits.
//            A debounced "next" button steps through channels; with the
//            SEG_PROBE_FREEZE_EN macro defined a "freeze" button holds the
//            display (a channel change while frozen takes one snapshot).
// Macro    : SEG_PROBE_FREEZE_EN - include the freeze button and logic.
// Revision : 1.0 - initial release
// ============================================================================

// Synchronizer + debouncer for one active-low button; pulses on press only.
module seg_probe_mux_db #(
  parameter int DB_CYCLES = 500000
) (
  input  wire clk,
  input  wire rst,
  input  wire key,
  output wire press
);
  localparam int              CNTW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(DB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            db_q;
  logic [CNTW-1:0] cnt_q;

  // Two-flop synchronizer, then count consecutive cycles that disagree with
  // the debounced level; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      db_q   <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key};
      if (sync_q[1] == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        db_q  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Fires in the cycle the debounced level falls from released to pressed
  assign press = db_q && !sync_q[1] && (cnt_q == LAST);
endmodule

module seg_probe_mux #(
  parameter int NCH       = 4,
  parameter int DW        = 32,
  parameter int NDIG      = 6,
  parameter int DB_CYCLES = 500000
) (
  input wire             clk,
  input wire             rst,
  seg_probe_mux_if.slave bus
);
  localparam int            CW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int            NIBW    = NDIG * 4;
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  logic [DW-1:0]     ch_word [NCH];
  logic [CW-1:0]     ch_sel_q;
  logic [DW-1:0]     disp_q;
  logic [NIBW-1:0]   disp_nib;
  logic [NDIG*7-1:0] hex_next;
  logic [NDIG*7-1:0] hex_q;
  logic              next_press;
  logic              disp_load;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign ch_word[i] = bus.probe[i*DW +: DW];
  end

  seg_probe_mux_db #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk   (clk),
    .rst   (rst),
    .key   (bus.key_next),
    .press (next_press)
  );

  // Channel select steps on each next press, wrapping at the last channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             ch_sel_q <= '0;
    else if (next_press) ch_sel_q <= (ch_sel_q == LAST_CH) ? '0 : ch_sel_q + 1'b1;
  end

`ifdef SEG_PROBE_FREEZE_EN
  logic freeze_press;
  logic frozen_q;
  logic snap_q;

  seg_probe_mux_db #(.DB_CYCLES(DB_CYCLES)) u_db_freeze (
    .clk   (clk),
    .rst   (rst),
    .key   (bus.key_freeze),
    .press (freeze_press)
  );

  // Freeze toggles per press; snap_q marks the cycle after a channel change
  // so a frozen display still picks up the newly selected channel once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frozen_q <= 1'b0;
      snap_q   <= 1'b0;
    end else begin
      frozen_q <= frozen_q ^ freeze_press;
      snap_q   <= next_press;
    end
  end

  assign disp_load  = !frozen_q || snap_q;
  assign bus.frozen = frozen_q;
`else
  logic unused_key_freeze;
  assign unused_key_freeze = bus.key_freeze;
  assign disp_load         = 1'b1;
  assign bus.frozen        = 1'b0;
`endif

  // Display register follows the selected channel whenever loading is allowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            disp_q <= '0;
    else if (disp_load) disp_q <= ch_word[ch_sel_q];
  end

  // Digits beyond the probe width read as zero via the zero-extending cast
  assign disp_nib = NIBW'(disp_q);

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    assign hex_next[k*7 +: 7] = seg7(disp_nib[k*4 +: 4]);
  end

  // Registered segment outputs; blank value after reset shows all zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex_q <= {NDIG{7'h40}};
    else     hex_q <= hex_next;
  end

  assign bus.hex    = hex_q;
  assign bus.ch_sel = ch_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_probe_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_probe_mux
// Purpose  : Self-checking bench for seg_probe_mux (NCH=4, DW=32, NDIG=6,
//            DB_CYCLES=4). Freeze expectations follow SEG_PROBE_FREEZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_probe_mux;
  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int NDIG = 6;
  localparam int DB   = 4;
`ifdef SEG_PROBE_FREEZE_EN
  localparam bit FREEZE_EN = 1'b1;
`else
  localparam bit FREEZE_EN = 1'b0;
`endif

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] L_BLANK    = {6{7'h40}};
  localparam logic [41:0] L_ABCDEF   = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] L_12345678 = {7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [41:0] L_BEEF     = {7'h40, 7'h40, 7'h03, 7'h06, 7'h06, 7'h0E};
  localparam logic [41:0] L_ONES     = {6{7'h79}};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] probe_v = '0;
  int                errors = 0;
  int                checks = 0;

  seg_probe_mux_if #(.NCH(NCH), .DW(DW), .NDIG(NDIG)) bus ();
  assign bus.probe = probe_v;

  seg_probe_mux #(.NCH(NCH), .DW(DW), .NDIG(NDIG), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_ch, m_prev_ch;
  bit          m_fro;
  logic [31:0] m_disp, m_hexsrc;
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_db [2];
  bit          m_hist [2][DB];
  int          m_fill [2];

  function automatic logic [41:0] enc(input logic [31:0] v);
    logic [41:0] r;
    for (int k = 0; k < NDIG; k++) r[k*7 +: 7] = SEG[v[k*4 +: 4]];
    return r;
  endfunction

  function automatic void model_reset();
    m_ch = 0; m_prev_ch = 0; m_fro = 1'b0; m_disp = '0; m_hexsrc = '0;
    for (int j = 0; j < 2; j++) begin
      m_s1[j] = 1'b1; m_s2[j] = 1'b1; m_db[j] = 1'b1; m_fill[j] = 0;
    end
  endfunction

  // A button level counts once the doubly-delayed raw level has been the
  // opposite of the stable level for the last DB samples in a row.
  function automatic void model_step();
    bit kin [2];
    bit pr  [2];
    bit all_opp, live;
    kin[0] = bus.key_next;
    kin[1] = bus.key_freeze;
    for (int j = 0; j < 2; j++) begin
      for (int k = DB - 1; k > 0; k--) m_hist[j][k] = m_hist[j][k-1];
      m_hist[j][0] = m_s2[j];
      if (m_fill[j] < DB) m_fill[j]++;
      all_opp = (m_fill[j] == DB);
      for (int k = 0; k < DB; k++) if (m_hist[j][k] == m_db[j]) all_opp = 1'b0;
      pr[j] = 1'b0;
      if (all_opp) begin
        m_db[j] = !m_db[j];
        pr[j]   = !m_db[j];
      end
      m_s2[j] = m_s1[j];
      m_s1[j] = kin[j];
    end
    live     = !m_fro || (m_ch != m_prev_ch);
    m_hexsrc = m_disp;
    if (live) m_disp = probe_v[m_ch*DW +: DW];
    m_prev_ch = m_ch;
    if (pr[0]) m_ch = (m_ch + 1) % NCH;
    if (FREEZE_EN && pr[1]) m_fro = !m_fro;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("ch_sel", 64'(bus.ch_sel), 64'(m_ch));
    chk("frozen", 64'(bus.frozen), 64'(m_fro));
    chk("hex", 64'(bus.hex), 64'(enc(m_hexsrc)));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] v);
    probe_v[i*DW +: DW] = v;
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) bus.key_next = 1'b0; else bus.key_freeze = 1'b0;
    tick(hold);
    if (which == 0) bus.key_next = 1'b1; else bus.key_freeze = 1'b1;
    tick(10);
  endtask

  initial begin
    int cn, cf;
    model_reset();
    bus.key_next   = 1'b1;
    bus.key_freeze = 1'b1;
    tick(3);
    rst = 1'b0;
    chk("lit_reset_ch", 64'(bus.ch_sel), 64'd0);
    chk("lit_reset_hex", 64'(bus.hex), 64'(L_BLANK));

    // Idle with random probe traffic
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, $urandom);
      tick(1);
    end

    // Display latency and encoding
    set_ch(0, 32'h00ABCDEF);
    tick(2);
    chk("lit_display", 64'(bus.hex), 64'(L_ABCDEF));

    // Bouncing next key: runs shorter than DB never register
    for (int i = 0; i < 15; i++) begin
      bus.key_next = ~bus.key_next;
      tick($urandom_range(1, DB - 1));
    end
    bus.key_next = 1'b1;
    tick(10);
    chk("lit_bounce", 64'(bus.ch_sel), 64'd0);

    // Four clean presses walk 1,2,3 and wrap to 0
    for (int p = 1; p <= 4; p++) begin
      press(0, DB + int'($urandom_range(0, 3)));
      chk("lit_wrap", 64'(bus.ch_sel), 64'(p % NCH));
    end

    // Freeze holds the display; a channel change takes a single snapshot
    set_ch(0, 32'h00ABCDEF);
    press(1, 5);
    set_ch(0, 32'h12345678);
    tick(3);
    chk("lit_freeze_hold", 64'(bus.hex), FREEZE_EN ? 64'(L_ABCDEF) : 64'(L_12345678));
    chk("lit_frozen", 64'(bus.frozen), 64'(FREEZE_EN));
    set_ch(1, 32'h0000BEEF);
    press(0, 5);
    chk("lit_snap_ch", 64'(bus.ch_sel), 64'd1);
    chk("lit_snap_hex", 64'(bus.hex), 64'(L_BEEF));
    for (int i = 0; i < 5; i++) begin
      set_ch(1, $urandom);
      tick(1);
    end
    set_ch(1, 32'h11111111);
    tick(3);
    chk("lit_snap_stay", 64'(bus.hex), FREEZE_EN ? 64'(L_BEEF) : 64'(L_ONES));

    // Reset mid-run clears outputs immediately
    rst = 1'b1;
    #1;
    chk("lit_rst_ch", 64'(bus.ch_sel), 64'd0);
    chk("lit_rst_frozen", 64'(bus.frozen), 64'd0);
    chk("lit_rst_hex", 64'(bus.hex), 64'(L_BLANK));
    tick(2);
    rst = 1'b0;
    tick(2);

    // Coincident next and freeze presses from unfrozen channel 0
    set_ch(0, 32'h0);
    set_ch(1, 32'h11111111);
    bus.key_next   = 1'b0;
    bus.key_freeze = 1'b0;
    tick(5);
    bus.key_next   = 1'b1;
    bus.key_freeze = 1'b1;
    tick(10);
    chk("lit_both_ch", 64'(bus.ch_sel), 64'd1);
    chk("lit_both_frozen", 64'(bus.frozen), 64'(FREEZE_EN));
    chk("lit_both_hex", 64'(bus.hex), 64'(L_ONES));
    for (int i = 0; i < 5; i++) begin
      set_ch(1, $urandom);
      tick(1);
    end

    // Reset in the middle of a debounce discards the press
    bus.key_next = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.key_next = 1'b1;
    tick(12);
    chk("lit_rst_debounce", 64'(bus.ch_sel), 64'd0);

    // Randomized buttons, probes and occasional resets
    cn = 0;
    cf = 0;
    for (int i = 0; i < 2500; i++) begin
      set_ch(int'($urandom_range(0, NCH - 1)), $urandom);
      if (cn == 0) begin
        bus.key_next = 1'($urandom_range(0, 1));
        cn = int'($urandom_range(1, 9));
      end else cn--;
      if (cf == 0) begin
        bus.key_freeze = 1'($urandom_range(0, 1));
        cf = int'($urandom_range(1, 9));
      end else cf--;
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seg_probe_mux.md
SEG_PROBE_MUX -- requirements
Module: seg_probe_mux

Interface
REQ-001 SHALL have parameter NCH, default 4: number of probe channels (2..16).
REQ-002 SHALL have parameter DW, default 32: width of each probe channel.
REQ-003 SHALL have parameter NDIG, default 6: number of seven-segment digits driven.
REQ-004 SHALL have parameter DB_CYCLES, default 500000: debounce stability length in clk cycles (10 ms at 50 MHz).
REQ-005 SHALL define localparam CW = clog2(NCH), minimum 1.
REQ-006 SHALL have port clk, input, 1: single clock; all state is on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port probe, input, NCH*DW: channel i is probe[i*DW +: DW]; asynchronous to nothing, sampled on clk.
REQ-009 SHALL have port key_next, input, 1: raw active-low push button; a press advances the channel.
REQ-010 SHALL have port key_freeze, input, 1: raw active-low push button; a press toggles freeze.
REQ-011 SHALL have port hex, output, NDIG*7: digit k is hex[7k +: 7], active-low, bit0 = segment a … bit6 = segment g.
REQ-012 SHALL have port ch_sel, output, CW: currently selected channel.
REQ-013 SHALL have port frozen, output, 1: 1 while the display is frozen.

Function
REQ-014 SHALL pass each key through a two-flop synchronizer before any other use.
REQ-015 SHALL debounce each synchronized key with its own counter:
- counter clears whenever the synchronized level equals the debounced state;
- when it differs for DB_CYCLES consecutive cycles, the debounced state takes the new level.
REQ-016 SHALL generate a one-cycle press pulse on each debounced 1->0 transition only; releases generate nothing.
REQ-017 SHALL increment ch_sel on a next-press pulse, wrapping NCH-1 -> 0; when NCH is not a power of two, ch_sel never exceeds NCH-1.
REQ-018 SHALL toggle frozen on a freeze-press pulse.
REQ-019 SHALL update display register disp_q (DW bits) every cycle with probe[ch_sel] while frozen is 0.
REQ-020 SHALL, while frozen is 1, hold disp_q, except for one snapshot of the new channel taken in the cycle after a ch_sel change.
REQ-021 SHALL, when next and freeze pulses coincide, apply both in the same cycle; if the result is frozen, the new-channel snapshot of REQ-020 is still taken.
REQ-022 SHALL register hex from disp_q: digit k shows hex nibble disp_q[4k+3:4k], giving 2-cycle latency from probe to hex.
REQ-023 SHALL encode nibbles as 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex values).
REQ-024 SHALL display digits with 4k >= DW as 0.

Reset
REQ-025 SHALL, on rst assertion, immediately set ch_sel=0, frozen=0, disp_q=0, every hex digit=7'h40, debounce counters=0, and debounced states and synchronizers=1 (released).
REQ-026 SHALL discard any press in progress when rst asserts mid-debounce; release after reset generates no pulse.

Configuration
REQ-027 SHALL, when SEG_PROBE_FREEZE_EN is defined, implement the key_freeze synchronizer, debouncer and freeze behaviour (REQ-018, REQ-020, REQ-021).
REQ-028 SHALL, when SEG_PROBE_FREEZE_EN is undefined, ignore key_freeze, tie frozen to 0, omit the freeze logic, and update disp_q every cycle.

Verification (NCH=4, DW=32, NDIG=6, DB_CYCLES=4, freeze enabled)
REQ-029 SHALL check reset: assert rst mid-run -> same cycle ch_sel=0, frozen=0, all six digits 7'h40.
REQ-030 SHALL check display: ch0 probe=32'h00ABCDEF -> 2 cycles later HEX0..HEX5 = 0E,06,21,46,03,08.
REQ-031 SHALL check debounce and wrap:
- key_next bouncing with runs <4 cycles -> no change;
- each clean low hold >=4 cycles -> exactly one increment;
- four presses from 0 -> ch_sel 1,2,3,0.
REQ-032 SHALL check freeze:
- press freeze, then change ch0 to 32'h12345678 -> hex unchanged;
- press next with ch1=32'h0000BEEF -> hex shows 00BEEF once, then stays fixed while ch1 changes.
REQ-033 SHALL check coincident presses: both pulses in one cycle from unfrozen ch0 -> ch_sel=1, frozen=1, disp_q = ch1 snapshot.
REQ-034 SHALL check reset mid-debounce: key_next low 2 cycles, rst pulse, key released -> ch_sel stays 0.
